// File: rtl/axi_lite_shared_arbiter_pkg.sv
// Shared definitions for the two-master AXI-Lite arbiter.
// Provides bus widths, response codes and the read/write FSM state encodings.
// No logic, so there is no latency and no backpressure behaviour.
package axi_lite_shared_arbiter_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_XFER,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/axi_lite_shared_arbiter_rr_arb2.sv
// Two-request round-robin grant: combinational grant plus a favoured-master pointer.
// Grant is combinational (0 cycles); the pointer updates on the clock after update.
// No backpressure: the caller decides when to take the grant by pulsing update.
// Ports: ACLK/ARESET (sync, active-high), req[1:0], update strobe, grant (0=M0, 1=M1).
module axi_lite_shared_arbiter_rr_arb2 #(
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic ptr;

    // The pointer only decides ties; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ptr;
        end else begin
            grant = req[1];
        end
    end

    // The pointer flips only when a tie was actually resolved, so a lone
    // requester does not steal the next tie-break from the other master.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ptr <= RESET_PRIO;
        end else if (update && (req == 2'b11)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/axi_lite_shared_arbiter.sv
// Two-master (M0 instruction, M1 data) to one-slave AXI-Lite arbiter, independent RR read/write paths.
// Latency: 1 cycle from master VALID to slave VALID (registered grant); one outstanding txn per path.
// Backpressure: slave READY is routed only to the granted master; losers wait with VALID held.
// Ports: ACLK/ARESET, AR/R/AW/W/B channels for masters (_M0, _M1) and the slave (_S, mirrored).
module axi_lite_shared_arbiter
    import axi_lite_shared_arbiter_pkg::*;
#(
    parameter int AXI_ADDR_BITS = axi_lite_shared_arbiter_pkg::AXI_ADDR_BITS,
    parameter int AXI_DATA_BITS = axi_lite_shared_arbiter_pkg::AXI_DATA_BITS,
    parameter int RESET_PRIO    = 0
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    // master 0
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
    input  logic                     ARVALID_M0,
    output logic                     ARREADY_M0,
    output logic [AXI_DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]               RRESP_M0,
    output logic                     RVALID_M0,
    input  logic                     RREADY_M0,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_M0,
    input  logic                     AWVALID_M0,
    output logic                     AWREADY_M0,
    input  logic [AXI_DATA_BITS-1:0] WDATA_M0,
    input  logic [3:0]               WSTRB_M0,
    input  logic                     WVALID_M0,
    output logic                     WREADY_M0,
    output logic [1:0]               BRESP_M0,
    output logic                     BVALID_M0,
    input  logic                     BREADY_M0,
    // master 1
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
    input  logic                     ARVALID_M1,
    output logic                     ARREADY_M1,
    output logic [AXI_DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]               RRESP_M1,
    output logic                     RVALID_M1,
    input  logic                     RREADY_M1,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_M1,
    input  logic                     AWVALID_M1,
    output logic                     AWREADY_M1,
    input  logic [AXI_DATA_BITS-1:0] WDATA_M1,
    input  logic [3:0]               WSTRB_M1,
    input  logic                     WVALID_M1,
    output logic                     WREADY_M1,
    output logic [1:0]               BRESP_M1,
    output logic                     BVALID_M1,
    input  logic                     BREADY_M1,
    // slave
    output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    output logic                     ARVALID_S,
    input  logic                     ARREADY_S,
    input  logic [AXI_DATA_BITS-1:0] RDATA_S,
    input  logic [1:0]               RRESP_S,
    input  logic                     RVALID_S,
    output logic                     RREADY_S,
    output logic [AXI_ADDR_BITS-1:0] AWADDR_S,
    output logic                     AWVALID_S,
    input  logic                     AWREADY_S,
    output logic [AXI_DATA_BITS-1:0] WDATA_S,
    output logic [3:0]               WSTRB_S,
    output logic                     WVALID_S,
    input  logic                     WREADY_S,
    input  logic [1:0]               BRESP_S,
    input  logic                     BVALID_S,
    output logic                     BREADY_S
);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_e rd_state, rd_next;
    logic      rd_gnt;       // registered owner of the read path
    logic      rd_arb_gnt;
    logic      rd_upd;
    logic      ar_vld, r_rdy;

    axi_lite_shared_arbiter_rr_arb2 #(.RESET_PRIO(RESET_PRIO != 0)) u_rd_arb (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .req    ({ARVALID_M1, ARVALID_M0}),
        .update (rd_upd),
        .grant  (rd_arb_gnt)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= R_IDLE;
            rd_gnt   <= 1'b0;
        end else begin
            rd_state <= rd_next;
            if (rd_upd) begin
                rd_gnt <= rd_arb_gnt;
            end
        end
    end

    // Every master-facing output is zero unless the state and grant select it,
    // which also keeps the idle and post-reset outputs quiet.
    always_comb begin
        rd_next    = rd_state;
        rd_upd     = 1'b0;
        ar_vld     = 1'b0;
        r_rdy      = 1'b0;
        ARADDR_S   = '0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        RDATA_M0   = '0;
        RRESP_M0   = '0;
        RVALID_M0  = 1'b0;
        RDATA_M1   = '0;
        RRESP_M1   = '0;
        RVALID_M1  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    rd_upd  = 1'b1;
                    rd_next = R_ADDR;
                end
            end
            R_ADDR: begin
                ar_vld    = rd_gnt ? ARVALID_M1 : ARVALID_M0;
                ARVALID_S = ar_vld;
                ARADDR_S  = rd_gnt ? ARADDR_M1 : ARADDR_M0;
                if (rd_gnt) ARREADY_M1 = ARREADY_S;
                else        ARREADY_M0 = ARREADY_S;
                if (ar_vld && ARREADY_S) rd_next = R_DATA;
            end
            R_DATA: begin
                r_rdy    = rd_gnt ? RREADY_M1 : RREADY_M0;
                RREADY_S = r_rdy;
                if (rd_gnt) begin
                    RVALID_M1 = RVALID_S;
                    RDATA_M1  = RDATA_S;
                    RRESP_M1  = RRESP_S;
                end else begin
                    RVALID_M0 = RVALID_S;
                    RDATA_M0  = RDATA_S;
                    RRESP_M0  = RRESP_S;
                end
                if (RVALID_S && r_rdy) rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_e wr_state, wr_next;
    logic      wr_gnt;
    logic      wr_arb_gnt;
    logic      wr_upd;
    logic      aw_done, w_done;   // sticky: channel already handshaken this burst
    logic      aw_vld, w_vld, b_rdy;
    logic      aw_hs, w_hs;

    axi_lite_shared_arbiter_rr_arb2 #(.RESET_PRIO(RESET_PRIO != 0)) u_wr_arb (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .req    ({AWVALID_M1 | WVALID_M1, AWVALID_M0 | WVALID_M0}),
        .update (wr_upd),
        .grant  (wr_arb_gnt)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state <= W_IDLE;
            wr_gnt   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_next;
            if (wr_upd) begin
                wr_gnt <= wr_arb_gnt;
            end
            if ((wr_state == W_XFER) && (wr_next == W_RESP)) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        wr_next    = wr_state;
        wr_upd     = 1'b0;
        aw_vld     = 1'b0;
        w_vld      = 1'b0;
        b_rdy      = 1'b0;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        AWADDR_S   = '0;
        AWVALID_S  = 1'b0;
        WDATA_S    = '0;
        WSTRB_S    = '0;
        WVALID_S   = 1'b0;
        BREADY_S   = 1'b0;
        AWREADY_M0 = 1'b0;
        AWREADY_M1 = 1'b0;
        WREADY_M0  = 1'b0;
        WREADY_M1  = 1'b0;
        BRESP_M0   = '0;
        BVALID_M0  = 1'b0;
        BRESP_M1   = '0;
        BVALID_M1  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (AWVALID_M0 || WVALID_M0 || AWVALID_M1 || WVALID_M1) begin
                    wr_upd  = 1'b1;
                    wr_next = W_XFER;
                end
            end
            W_XFER: begin
                // A finished channel is masked in both directions so a master
                // that keeps VALID high cannot push a second beat.
                aw_vld    = !aw_done && (wr_gnt ? AWVALID_M1 : AWVALID_M0);
                w_vld     = !w_done  && (wr_gnt ? WVALID_M1  : WVALID_M0);
                AWVALID_S = aw_vld;
                WVALID_S  = w_vld;
                AWADDR_S  = wr_gnt ? AWADDR_M1 : AWADDR_M0;
                WDATA_S   = wr_gnt ? WDATA_M1  : WDATA_M0;
                WSTRB_S   = wr_gnt ? WSTRB_M1  : WSTRB_M0;
                if (wr_gnt) begin
                    AWREADY_M1 = !aw_done && AWREADY_S;
                    WREADY_M1  = !w_done  && WREADY_S;
                end else begin
                    AWREADY_M0 = !aw_done && AWREADY_S;
                    WREADY_M0  = !w_done  && WREADY_S;
                end
                aw_hs = aw_vld && AWREADY_S;
                w_hs  = w_vld  && WREADY_S;
                if ((aw_done || aw_hs) && (w_done || w_hs)) wr_next = W_RESP;
            end
            W_RESP: begin
                b_rdy    = wr_gnt ? BREADY_M1 : BREADY_M0;
                BREADY_S = b_rdy;
                if (wr_gnt) begin
                    BVALID_M1 = BVALID_S;
                    BRESP_M1  = BRESP_S;
                end else begin
                    BVALID_M0 = BVALID_S;
                    BRESP_M0  = BRESP_S;
                end
                if (BVALID_S && b_rdy) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

endmodule
